fp_div: RTL and testbench
=========================

# fp_div

Sequential IEEE-754 half-precision divider for the systolic-array datapath and the inverse of the team's combinational FP16 multiplier. It uses the same number conventions: truncation rounding, exponent 31 treated as infinity with zero mantissa, and full denormal input and output support. It computes `opA_i / opB_i` with a 13-step restoring division, using a start/done handshake and a registered result.

## Interface
- No parameters; format fixed at FP16 (1 sign, 5 exponent, 10 mantissa bits, bias 15).
- `clk_i` in 1 — single clock; all state changes on the rising edge.
- `rst_i` in 1 — asynchronous, active-high reset.
- `start_i` in 1 — request; sampled only in IDLE.
- `opA_i` in 16 — dividend; captured on the accepting edge.
- `opB_i` in 16 — divisor; captured on the accepting edge.
- `busy_o` out 1 — high whenever the state is not IDLE.
- `done_o` out 1 — one-cycle pulse; `DIV_o` is valid from this cycle on.
- `DIV_o` out 16 — quotient; holds its value until the next completion.
- `div_by_zero_o` out 1 — registered with `DIV_o`; high when the divisor was ±0.

## Operation
- States: IDLE, DIV, PACK. IDLE+start_i → DIV, or → PACK if a special case applies. DIV runs 13 cycles with a 4-bit counter, then → PACK. PACK → IDLE.
- Sign = A[15]^B[15]; it is applied to every result, including zero and infinity.
- Special cases, checked in priority order at accept:
  1. A exp = 31 → inf.
  2. B is ±0 (exp 0, mantissa 0) → inf, `div_by_zero_o`=1.
  3. B exp = 31 → zero.
  4. A is ±0 → zero.
- Inf = {s,5'h1F,10'h0}; zero = {s,15'h0}. NaN is not distinguished from infinity.
- Normalisation at accept:
  - Normal operand: significand = {1,mant} (11 bits); effective exponent e = exp.
  - Denormal operand: shift mant left by s until bit 10 is set; e = 1−s.
  - Exponents are held as 7-bit signed values.
- Division loop:
  - Remainder is 12 bits, initialised to ma. Each DIV cycle: if rem ≥ mb, the quotient bit is 1 and rem −= mb, else the bit is 0; then rem <<= 1.
  - Quotient bits shift in MSB-first into a 13-bit Q.
  - After 13 cycles Q = floor(ma·2^12/mb), in the range [2^11, 2^13).
- PACK:
  - If Q[12]=1: S = Q[12:2], adj = 0. Otherwise: S = Q[11:1], adj = −1.
  - E = ea − eb + 15 + adj (signed).
  - E ≥ 31 → inf, `div_by_zero_o`=0.
  - 1 ≤ E ≤ 30 → {s, E[4:0], S[9:0]}.
  - E ≤ 0 → denormal, mantissa = (S >> (1−E))[9:0]. If 1−E ≥ 11 the result is zero.
  - All rounding is truncation; remainder bits are discarded.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `DIV_o`=16'h0000, `div_by_zero_o`=0; state = IDLE.
- Latency, measured from the accepting edge (edge 0):
  - Normal path: `DIV_o` and `done_o` are registered at edge 14, so `done_o` is high for cycle 14 only.
  - Special path: registered at edge 1.
- `busy_o` rises at edge 0. It falls at the edge where `done_o` rises.
- `start_i` is ignored while busy. Operand changes while busy are ignored.
- `start_i` during the `done_o` cycle is accepted (state is IDLE); back-to-back throughput is one result every 15 cycles.
- `rst_i` asserted mid-operation: outputs and state clear immediately. No `done_o` pulse follows for the aborted operation.

## Test plan
- `3C00`/`3C00` (1.0/1.0) → `DIV_o`=3C00, `done_o` exactly 14 cycles after the accepting edge, `busy_o` high for cycles 0–13.
- `4600`/`C000` (6.0/−2.0) → C200. Then `3C00`/`4200` (1.0/3.0) → 3555, truncated, started in the `done_o` cycle of the first operation.
- `3C00`/`0000` → 7C00 with `div_by_zero_o`=1, latency 1. `BC00`/`0000` → FC00. `0000`/`3C00` → 0000. `3C00`/`7C00` → 0000.
- Underflow and denormals:
  - `0400`/`4000` → 0200 (denormal output).
  - `0001`/`3800` (min denormal / 0.5) → 0002 (denormal input).
  - `0001`/`4400` → 0000 (flush to zero).
- Overflow: `7BFF`/`2C00` (65504/0.0625) → 7C00 with `div_by_zero_o`=0.
- Assert `rst_i` at cycle 6 of a division → all outputs 0 at once, no later `done_o`. A `start_i` pulse during busy has no effect, and the original result is unchanged.

Source files
------------

// File: rtl/fp_div.sv
// fp_div: sequential FP16 (1/5/10, bias 15) divider, DIV_o = opA_i / opB_i.
// Restoring division producing 13 quotient bits, truncation rounding,
// denormal inputs and outputs, exponent 31 treated as infinity (no NaN).
// Ports:
//   clk_i, rst_i (async, active-high)
//   start_i        - request, sampled only while idle
//   opA_i, opB_i   - dividend / divisor, captured on the accepting edge
//   busy_o         - high while a division is in flight
//   done_o         - one-cycle pulse when DIV_o / div_by_zero_o update
//   DIV_o          - quotient, held until the next completion
//   div_by_zero_o  - divisor was +/-0 (registered with DIV_o)
module fp_div (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] opA_i,
    input  logic [15:0] opB_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] DIV_o,
    output logic        div_by_zero_o
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_PACK = 2'd2} state_t;

    // Returns {effective exponent (7-bit signed), 11-bit significand with bit 10 set}.
    // Denormals are shifted up until the hidden bit position is occupied, e = 1 - shift.
    function automatic logic [17:0] normalize(input logic [14:0] mag);
        logic [10:0] sig;
        logic [6:0]  e;
        if (mag[14:10] != 5'd0) begin
            sig = {1'b1, mag[9:0]};
            e   = {2'b00, mag[14:10]};
        end else begin
            sig = {1'b0, mag[9:0]};
            e   = 7'd1;
            for (int i = 0; i < 11; i++) begin
                if (!sig[10]) begin
                    sig = {sig[9:0], 1'b0};
                    e   = e - 7'd1;
                end else begin
                    e   = e;
                end
            end
        end
        return {e, sig};
    endfunction

    // Builds the final FP16 word from sign, biased exponent base and raw quotient.
    function automatic logic [15:0] pack(input logic s, input logic [6:0] ebase,
                                         input logic [12:0] q);
        logic [10:0] sm;
        logic [10:0] tmp;
        logic [6:0]  e;
        logic [6:0]  sh;
        logic [15:0] res;
        if (q[12]) begin
            sm = q[12:2];
            e  = ebase;
        end else begin
            sm = q[11:1];
            e  = ebase - 7'd1;
        end
        sh  = 7'd1 - e;
        tmp = 11'd0;
        // e[6] is the sign bit of the 7-bit signed exponent
        if (!e[6] && (e >= 7'd31)) begin
            res = {s, 5'h1F, 10'h000};
        end else if (!e[6] && (e != 7'd0)) begin
            res = {s, e[4:0], sm[9:0]};
        end else if (sh >= 7'd11) begin
            res = {s, 15'h0000};
        end else begin
            tmp = sm >> sh[3:0];
            res = {s, 5'h00, tmp[9:0]};
        end
        return res;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] rem_q, rem_d;
    logic [10:0] mb_q, mb_d;
    logic [12:0] quo_q, quo_d;
    logic [6:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        spec_q, spec_d;
    logic [15:0] spec_res_q, spec_res_d;
    logic        spec_dbz_q, spec_dbz_d;
    logic        done_q, done_d;
    logic [15:0] div_q, div_d;
    logic        dbz_q, dbz_d;

    logic [17:0] na_s, nb_s;
    logic        s_s;

    assign na_s = normalize(opA_i[14:0]);
    assign nb_s = normalize(opB_i[14:0]);
    assign s_s  = opA_i[15] ^ opB_i[15];

    // Next-state logic: accept/special detection, one division step per cycle, pack.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        mb_d       = mb_q;
        quo_d      = quo_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        spec_dbz_d = spec_dbz_q;
        done_d     = 1'b0;
        div_d      = div_q;
        dbz_d      = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sign_d     = s_s;
                    rem_d      = {1'b0, na_s[10:0]};
                    mb_d       = nb_s[10:0];
                    exp_d      = na_s[17:11] - nb_s[17:11] + 7'd15;
                    quo_d      = 13'd0;
                    cnt_d      = 4'd0;
                    spec_d     = 1'b1;
                    spec_dbz_d = 1'b0;
                    // Special cases in priority order
                    if (opA_i[14:10] == 5'h1F) begin
                        spec_res_d = {s_s, 5'h1F, 10'h000};
                    end else if (opB_i[14:0] == 15'h0000) begin
                        spec_res_d = {s_s, 5'h1F, 10'h000};
                        spec_dbz_d = 1'b1;
                    end else if (opB_i[14:10] == 5'h1F) begin
                        spec_res_d = {s_s, 15'h0000};
                    end else if (opA_i[14:0] == 15'h0000) begin
                        spec_res_d = {s_s, 15'h0000};
                    end else begin
                        spec_d     = 1'b0;
                        spec_res_d = 16'h0000;
                    end
                    state_d = spec_d ? S_PACK : S_DIV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                // Remainder stays below 2^11 after each step, so the shift never overflows
                if (rem_q >= {1'b0, mb_q}) begin
                    quo_d = {quo_q[11:0], 1'b1};
                    rem_d = (rem_q - {1'b0, mb_q}) << 1;
                end else begin
                    quo_d = {quo_q[11:0], 1'b0};
                    rem_d = rem_q << 1;
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd12) begin
                    state_d = S_PACK;
                end else begin
                    state_d = S_DIV;
                end
            end
            S_PACK: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (spec_q) begin
                    div_d = spec_res_q;
                    dbz_d = spec_dbz_q;
                end else begin
                    div_d = pack(sign_q, exp_q, quo_q);
                    dbz_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rem_q      <= 12'd0;
            mb_q       <= 11'd0;
            quo_q      <= 13'd0;
            exp_q      <= 7'd0;
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= 16'h0000;
            spec_dbz_q <= 1'b0;
            done_q     <= 1'b0;
            div_q      <= 16'h0000;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            mb_q       <= mb_d;
            quo_q      <= quo_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            spec_dbz_q <= spec_dbz_d;
            done_q     <= done_d;
            div_q      <= div_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign DIV_o         = div_q;
    assign div_by_zero_o = dbz_q;
endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: directed self-checking bench for fp_div (hand-computed vectors).
module tb_fp_div;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] opA_i;
    logic [15:0] opB_i;
    logic        busy_o;
    logic        done_o;
    logic [15:0] DIV_o;
    logic        div_by_zero_o;

    int checks = 0;
    int errors = 0;

    fp_div dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .opA_i         (opA_i),
        .opB_i         (opB_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .DIV_o         (DIV_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge. Issues one operation, waits for done_o
    // with a bound, and checks latency, busy profile and result. With poke set,
    // a stray start pulse with different operands is driven mid-division.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_q, input logic exp_dbz,
                          input int exp_lat, input bit poke);
        int lat;
        int busy_bad;
        start_i = 1'b1;
        opA_i   = a;
        opB_i   = b;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
        lat      = 0;
        busy_bad = 0;
        while (!done_o && lat < 40) begin
            if (!busy_o) busy_bad++;
            if (poke && lat == 5) begin
                start_i = 1'b1;
                opA_i   = 16'h3C00;
                opB_i   = 16'h4200;
            end else if (poke && lat == 6) begin
                start_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_during"}, busy_bad, 0);
        check({tag, "_busy_after"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_div"}, {16'd0, DIV_o}, {16'd0, exp_q});
        check({tag, "_dbz"}, {31'd0, div_by_zero_o}, {31'd0, exp_dbz});
    endtask

    initial begin
        int done_seen;
        rst_i   = 1'b1;
        start_i = 1'b0;
        opA_i   = 16'h0000;
        opB_i   = 16'h0000;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_div", {16'd0, DIV_o}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        run_op("one_by_one", 16'h3C00, 16'h3C00, 16'h3C00, 1'b0, 14, 1'b0);
        run_op("six_by_m2", 16'h4600, 16'hC000, 16'hC200, 1'b0, 14, 1'b0);
        // Started in the done_o cycle of the previous operation
        run_op("one_third", 16'h3C00, 16'h4200, 16'h3555, 1'b0, 14, 1'b0);
        run_op("pos_by_zero", 16'h3C00, 16'h0000, 16'h7C00, 1'b1, 1, 1'b0);
        run_op("neg_by_zero", 16'hBC00, 16'h0000, 16'hFC00, 1'b1, 1, 1'b0);
        run_op("zero_by_one", 16'h0000, 16'h3C00, 16'h0000, 1'b0, 1, 1'b0);
        run_op("one_by_inf", 16'h3C00, 16'h7C00, 16'h0000, 1'b0, 1, 1'b0);
        run_op("denorm_out", 16'h0400, 16'h4000, 16'h0200, 1'b0, 14, 1'b0);
        run_op("denorm_in", 16'h0001, 16'h3800, 16'h0002, 1'b0, 14, 1'b0);
        run_op("flush_zero", 16'h0001, 16'h4400, 16'h0000, 1'b0, 14, 1'b0);
        run_op("overflow", 16'h7BFF, 16'h2C00, 16'h7C00, 1'b0, 14, 1'b0);
        run_op("start_ignored", 16'h4600, 16'hC000, 16'hC200, 1'b0, 14, 1'b1);

        // Abort a division with reset at cycle 6
        start_i = 1'b1;
        opA_i   = 16'h3C00;
        opB_i   = 16'h4200;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_done", {31'd0, done_o}, 32'd0);
        check("abort_div", {16'd0, DIV_o}, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        run_op("after_abort", 16'h3C00, 16'h4200, 16'h3555, 1'b0, 14, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
